// File: rtl/ahb_pkg.sv
// Shared types and constants for the AHB-Lite master and its lane-steering helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_B = 3'b000;
    localparam logic [2:0] HSIZE_H = 3'b001;
    localparam logic [2:0] HSIZE_W = 3'b010;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StErr,
        StLerr
    } mst_state_t;

    typedef enum logic [1:0] {
        RegNone,
        RegRom,
        RegRam
    } region_t;

    function automatic logic [2:0] fn3_to_hsize(input logic [2:0] fn3);
        logic [2:0] size;
        case (fn3)
            F3_B, F3_BU: size = HSIZE_B;
            F3_H, F3_HU: size = HSIZE_H;
            default:     size = HSIZE_W;
        endcase
        return size;
    endfunction

    // Undefined funct3 encodings are moved as words but are not alignment-checked.
    function automatic logic is_misaligned(input logic [2:0] fn3, input logic [1:0] addr_lo);
        logic mis;
        case (fn3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// Store byte-lane replication and load lane selection with sign/zero extension.
module ahb_lane_steer
    import ahb_pkg::*;
(
    input  logic [2:0]  fn3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] hwdata_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        hwdata_o = wdata_i;
        case (fn3_i)
            F3_B, F3_BU: hwdata_o = {4{wdata_i[7:0]}};
            F3_H, F3_HU: hwdata_o = {2{wdata_i[15:0]}};
            default:     hwdata_o = wdata_i;
        endcase
    end

    always_comb begin
        load_o = rdata_i;
        case (fn3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_o = {24'h000000, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_o = {16'h0000, half_sel};
            default: load_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/ahb_lite_master.sv
// Registered single-outstanding AHB-Lite master for core load/store/fetch requests.
// Misaligned, unmapped and ROM-write requests are rejected locally without bus activity.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int unsigned         TAG_W     = 8,
    parameter logic [TAG_W-1:0]    ROM_TAG   = 8'hA0,
    parameter logic [TAG_W-1:0]    RAM_TAG   = 8'hB0,
    parameter logic [3:0]          ROM_HPROT = 4'b0000,
    parameter logic [3:0]          RAM_HPROT = 4'b0001
) (
    input  logic        hclk,
    input  logic        hresetn,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_fn3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    mst_state_t  state_q;
    logic [1:0]  addr_lo_q;
    logic        write_q;
    logic [2:0]  fn3_q;
    region_t     region_q;
    logic [31:0] wdata_q;

    htrans_t     htrans_q;
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [3:0]  hprot_q;
    logic [31:0] hwdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        req_ready_q;

    region_t     req_region;
    logic        req_local_err;
    logic [31:0] store_lanes;
    logic [31:0] load_ext;

    always_comb begin
        req_region = RegNone;
        if (req_addr[31:32-TAG_W] == ROM_TAG) begin
            req_region = RegRom;
        end else if (req_addr[31:32-TAG_W] == RAM_TAG) begin
            req_region = RegRam;
        end
        req_local_err = is_misaligned(req_fn3, req_addr[1:0]) ||
                        (req_region == RegNone) ||
                        ((req_region == RegRom) && req_write);
    end

    ahb_lane_steer u_lane_steer (
        .fn3_i     (fn3_q),
        .addr_lo_i (addr_lo_q),
        .wdata_i   (wdata_q),
        .rdata_i   (hrdata),
        .hwdata_o  (store_lanes),
        .load_o    (load_ext)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= StIdle;
            addr_lo_q   <= 2'b00;
            write_q     <= 1'b0;
            fn3_q       <= 3'b000;
            region_q    <= RegNone;
            wdata_q     <= 32'h0;
            htrans_q    <= TransIdle;
            haddr_q     <= 32'h0;
            hwrite_q    <= 1'b0;
            hsize_q     <= HSIZE_W;
            hprot_q     <= 4'b0000;
            hwdata_q    <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_lo_q   <= req_addr[1:0];
                        write_q     <= req_write;
                        fn3_q       <= req_fn3;
                        region_q    <= req_region;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_local_err) begin
                            state_q <= StLerr;
                        end else begin
                            // Address phase is presented from the accept edge onward.
                            state_q  <= StAddr;
                            htrans_q <= TransNonseq;
                            haddr_q  <= req_addr;
                            hwrite_q <= req_write;
                            hsize_q  <= fn3_to_hsize(req_fn3);
                            hprot_q  <= (req_region == RegRom) ? ROM_HPROT : RAM_HPROT;
                        end
                    end
                end
                StAddr: begin
                    if (hready) begin
                        state_q  <= StData;
                        htrans_q <= TransIdle;
                        hwdata_q <= store_lanes;
                    end
                end
                StData: begin
                    if (hready) begin
                        // hresp with hready high is out of protocol; report it as an error.
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= hresp;
                        rsp_rdata_q <= (hresp || write_q) ? 32'h0 : load_ext;
                    end else if (hresp) begin
                        state_q <= StErr;
                    end
                end
                StErr: begin
                    if (hready) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'h0;
                    end
                end
                StLerr: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= 32'h0;
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    htrans_q    <= TransIdle;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign htrans    = htrans_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hprot     = hprot_q;
    assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with hand-computed expected values.
module tb_ahb_lite_master;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_fn3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    always #5 hclk = ~hclk;

    ahb_lite_master dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_fn3   (req_fn3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .htrans    (htrans),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hprot     (hprot),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Returns one time unit after the accepting edge.
    task automatic issue(input logic wr, input logic [2:0] fn3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_fn3   = fn3;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic load0(input string tag, input logic [2:0] fn3, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp);
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = rd;
        issue(1'b0, fn3, addr, 32'h0);
        chk({tag, "_htrans_addr"}, 32'(htrans), 32'd2);
        tick();
        chk({tag, "_htrans_data"}, 32'(htrans), 32'd0);
        chk({tag, "_rsp_early"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, exp);
        chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    endtask

    task automatic reject(input string tag, input logic wr, input logic [2:0] fn3,
                          input logic [31:0] addr);
        hready = 1'b1;
        hresp  = 1'b0;
        issue(wr, fn3, addr, 32'h5555_AAAA);
        chk({tag, "_no_nonseq"}, 32'(htrans), 32'd0);
        chk({tag, "_rsp_early"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_err"}, 32'(rsp_err), 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_htrans"}, 32'(htrans), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_htrans"}, 32'(htrans), 32'd0);
        chk({tag, "_haddr"}, haddr, 32'h0);
        chk({tag, "_hwrite"}, 32'(hwrite), 32'd0);
        chk({tag, "_hsize"}, 32'(hsize), 32'd2);
        chk({tag, "_hprot"}, 32'(hprot), 32'd0);
        chk({tag, "_hwdata"}, hwdata, 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        hresetn   = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_fn3   = 3'b010;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        hrdata    = 32'h0;
        hready    = 1'b1;
        hresp     = 1'b0;
        #2 hresetn = 1'b0;
        #10;
        check_reset_outputs("rst");
        @(negedge hclk);
        hresetn = 1'b1;
        tick();

        // LW, zero wait states
        hrdata = 32'hDEAD_BEEF;
        issue(1'b0, 3'b010, 32'hB000_0010, 32'h0);
        chk("lw_htrans", 32'(htrans), 32'd2);
        chk("lw_haddr", haddr, 32'hB000_0010);
        chk("lw_hsize", 32'(hsize), 32'd2);
        chk("lw_hprot", 32'(hprot), 32'd1);
        chk("lw_hwrite", 32'(hwrite), 32'd0);
        chk("lw_ready_low", 32'(req_ready), 32'd0);
        tick();
        chk("lw_htrans_data", 32'(htrans), 32'd0);
        chk("lw_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("lw_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("lw_err", 32'(rsp_err), 32'd0);
        chk("lw_ready_back", 32'(req_ready), 32'd1);
        tick();
        chk("lw_rsp_pulse", 32'(rsp_valid), 32'd0);

        load0("lb",  3'b000, 32'hB000_0003, 32'h80AA_BBCC, 32'hFFFF_FF80);
        load0("lbu", 3'b100, 32'hB000_0003, 32'h80AA_BBCC, 32'h0000_0080);
        load0("lhu", 3'b101, 32'hB000_0002, 32'h80AA_BBCC, 32'h0000_80AA);
        load0("lh",  3'b001, 32'hB000_0002, 32'h80AA_BBCC, 32'hFFFF_80AA);
        load0("lb1", 3'b000, 32'hB000_0001, 32'h80AA_3BCC, 32'h0000_003B);

        // SB with two ADDR wait states and one DATA wait state
        hready = 1'b1;
        issue(1'b1, 3'b000, 32'hB000_0001, 32'h1234_5677);
        hready = 1'b0;
        chk("sb_htrans0", 32'(htrans), 32'd2);
        chk("sb_haddr0", haddr, 32'hB000_0001);
        chk("sb_hsize0", 32'(hsize), 32'd0);
        chk("sb_hwrite0", 32'(hwrite), 32'd1);
        tick();
        chk("sb_htrans1", 32'(htrans), 32'd2);
        chk("sb_haddr1", haddr, 32'hB000_0001);
        chk("sb_hsize1", 32'(hsize), 32'd0);
        tick();
        chk("sb_htrans2", 32'(htrans), 32'd2);
        chk("sb_haddr2", haddr, 32'hB000_0001);
        hready = 1'b1;
        tick();
        hready = 1'b0;
        chk("sb_htrans_data", 32'(htrans), 32'd0);
        chk("sb_hwdata", hwdata, 32'h7777_7777);
        tick();
        chk("sb_hwdata_hold", hwdata, 32'h7777_7777);
        chk("sb_rsp_early", 32'(rsp_valid), 32'd0);
        hready = 1'b1;
        tick();
        chk("sb_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("sb_err", 32'(rsp_err), 32'd0);
        chk("sb_rdata", rsp_rdata, 32'h0);

        // Two-cycle slave ERROR on a ROM load
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = 32'h1111_2222;
        issue(1'b0, 3'b010, 32'hA000_0000, 32'h0);
        chk("err_htrans", 32'(htrans), 32'd2);
        chk("err_hprot", 32'(hprot), 32'd0);
        tick();
        hready = 1'b0;
        hresp  = 1'b1;
        tick();
        chk("err_first_no_rsp", 32'(rsp_valid), 32'd0);
        chk("err_htrans_idle", 32'(htrans), 32'd0);
        hready = 1'b1;
        tick();
        hresp = 1'b0;
        chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("err_rsp_err", 32'(rsp_err), 32'd1);
        chk("err_rdata", rsp_rdata, 32'h0);

        reject("rom_sw", 1'b1, 3'b010, 32'hA000_0004);
        reject("mis_lw", 1'b0, 3'b010, 32'hB000_0002);
        reject("unmap",  1'b0, 3'b010, 32'hC000_0000);

        // Reset asserted while the data phase is stalled
        hready = 1'b1;
        issue(1'b0, 3'b010, 32'hB000_0020, 32'h0);
        tick();
        hready = 1'b0;
        tick();
        chk("mid_in_data", 32'(htrans), 32'd0);
        chk("mid_haddr", haddr, 32'hB000_0020);
        #2 hresetn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        hready = 1'b1;
        @(negedge hclk);
        hresetn = 1'b1;
        tick();
        chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        load0("post_lw", 3'b010, 32'hB000_0040, 32'h1357_9BDF, 32'h1357_9BDF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
